exe_stage_md: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage. It computes the ALU result and passes the store value and memory read/write enables through an internal EXE/MEM pipeline register. It also contains an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers. While that unit is busy, it stalls the front of the pipeline.

---
 rtl/exe_stage_md.sv | 215 +++++++++++++++++++++
 tb/tb_exe_stage_md.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage of the 5-stage MIPS pipeline.
// Computes the ALU result and registers it, together with store data and
// memory/writeback control, into the EXE/MEM register. It also holds an
// iterative 32-cycle unsigned multiply/divide unit with HI/LO registers.
// While that unit is busy, the stage stalls the front of the pipeline.
// Optional feature macro: EXE_DIV_EN compiles in the DIVU path. Without it,
// EXE_CMD 10 is a single-cycle op with result 0.
module exe_stage_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] ST_val_in,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             WB_EN_in,
    input  logic [4:0]       Dest_in,
    input  logic             freeze,
    output logic             stall,
    output logic [WIDTH-1:0] ALU_Res,
    output logic [WIDTH-1:0] ST_val,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             WB_EN,
    output logic [4:0]       Dest
);

    localparam logic [3:0] CMD_ADD   = 4'd0;
    localparam logic [3:0] CMD_SUB   = 4'd1;
    localparam logic [3:0] CMD_AND   = 4'd2;
    localparam logic [3:0] CMD_OR    = 4'd3;
    localparam logic [3:0] CMD_NOR   = 4'd4;
    localparam logic [3:0] CMD_XOR   = 4'd5;
    localparam logic [3:0] CMD_SLL   = 4'd6;
    localparam logic [3:0] CMD_SRA   = 4'd7;
    localparam logic [3:0] CMD_SRL   = 4'd8;
    localparam logic [3:0] CMD_MULTU = 4'd9;
`ifdef EXE_DIV_EN
    localparam logic [3:0] CMD_DIVU  = 4'd10;
`endif
    localparam logic [3:0] CMD_MFHI  = 4'd11;
    localparam logic [3:0] CMD_MFLO  = 4'd12;
    localparam logic [4:0] CNT_LAST  = 5'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    md_state_t        state_r;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] md_hi_r;   // partial product high half / running remainder
    logic [WIDTH-1:0] md_lo_r;   // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] md_b_r;    // multiplicand / divisor
`ifdef EXE_DIV_EN
    logic             is_div_r;
    logic             div_top_s;
    logic [WIDTH-1:0] div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_ge_s;
`endif

    logic [WIDTH-1:0] alu_s;
    logic             md_start_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [WIDTH-1:0] nxt_alu_s;
    logic [WIDTH-1:0] nxt_st_s;
    logic [2:0]       nxt_ctl_s;
    logic [4:0]       nxt_dest_s;

    assign stall = (state_r == ST_BUSY) | freeze;

`ifdef EXE_DIV_EN
    assign md_start_s = valid_in && ((EXE_CMD == CMD_MULTU) || (EXE_CMD == CMD_DIVU));
`else
    assign md_start_s = valid_in && (EXE_CMD == CMD_MULTU);
`endif

    // Single-cycle ALU result; unused codes (and DIVU when not built) give 0.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (EXE_CMD)
            CMD_ADD:  alu_s = val1 + val2;
            CMD_SUB:  alu_s = val1 - val2;
            CMD_AND:  alu_s = val1 & val2;
            CMD_OR:   alu_s = val1 | val2;
            CMD_NOR:  alu_s = ~(val1 | val2);
            CMD_XOR:  alu_s = val1 ^ val2;
            CMD_SLL:  alu_s = val1 << val2[4:0];
            CMD_SRA:  alu_s = $unsigned($signed(val1) >>> val2[4:0]);
            CMD_SRL:  alu_s = val1 >> val2[4:0];
            CMD_MFHI: alu_s = hi_r;
            CMD_MFLO: alu_s = lo_r;
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s = {1'b0, md_hi_r} + (md_lo_r[0] ? {1'b0, md_b_r} : {(WIDTH+1){1'b0}});
        step_hi_s = mul_sum_s[WIDTH:1];
        step_lo_s = {mul_sum_s[0], md_lo_r[WIDTH-1:1]};
`ifdef EXE_DIV_EN
        // Remainder shifted left by one, top bit kept apart so the trial
        // subtraction stays WIDTH bits wide; a set top bit always fits.
        div_top_s   = md_hi_r[WIDTH-1];
        div_shift_s = {md_hi_r[WIDTH-2:0], md_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - md_b_r;
        div_ge_s    = div_top_s | (div_shift_s >= md_b_r);
        if (is_div_r) begin
            if (div_ge_s) begin
                step_hi_s = div_diff_s;
                step_lo_s = {md_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s;
                step_lo_s = {md_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], md_lo_r[WIDTH-1:1]};
        end
`endif
    end

    // Next EXE/MEM contents: a real single-cycle op passes through, else bubble.
    always_comb begin
        if ((state_r == ST_IDLE) && valid_in && !md_start_s) begin
            nxt_alu_s  = alu_s;
            nxt_st_s   = ST_val_in;
            nxt_ctl_s  = {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in};
            nxt_dest_s = Dest_in;
        end else begin
            nxt_alu_s  = {WIDTH{1'b0}};
            nxt_st_s   = {WIDTH{1'b0}};
            nxt_ctl_s  = 3'b000;
            nxt_dest_s = 5'd0;
        end
    end

    // EXE/MEM pipeline register; freeze holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Res  <= {WIDTH{1'b0}};
            ST_val   <= {WIDTH{1'b0}};
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            WB_EN    <= 1'b0;
            Dest     <= 5'd0;
        end else if (!freeze) begin
            ALU_Res  <= nxt_alu_s;
            ST_val   <= nxt_st_s;
            {MEM_R_EN, MEM_W_EN, WB_EN} <= nxt_ctl_s;
            Dest     <= nxt_dest_s;
        end
    end

    // Multiply/divide FSM: latch operands, iterate 32 times, commit HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            md_hi_r  <= {WIDTH{1'b0}};
            md_lo_r  <= {WIDTH{1'b0}};
            md_b_r   <= {WIDTH{1'b0}};
`ifdef EXE_DIV_EN
            is_div_r <= 1'b0;
`endif
        end else if (!freeze) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 5'd0;
                    if (md_start_s) begin
                        state_r <= ST_BUSY;
                        md_hi_r <= {WIDTH{1'b0}};
`ifdef EXE_DIV_EN
                        is_div_r <= (EXE_CMD == CMD_DIVU);
                        md_b_r   <= (EXE_CMD == CMD_DIVU) ? val2 : val1;
                        md_lo_r  <= (EXE_CMD == CMD_DIVU) ? val1 : val2;
`else
                        md_b_r   <= val1;
                        md_lo_r  <= val2;
`endif
                    end
                end
                ST_BUSY: begin
                    md_hi_r <= step_hi_s;
                    md_lo_r <= step_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        hi_r    <= step_hi_s;
                        lo_r    <= step_lo_s;
                        state_r <= ST_IDLE;
                        cnt_r   <= 5'd0;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage_md.sv
// Self-checking bench for exe_stage_md: scoreboard of expected EXE/MEM
// register contents plus HI/LO reference model and stall-length checks.
module tb_exe_stage_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] ST_val_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic        WB_EN_in;
    logic [4:0]  Dest_in;
    logic        freeze;
    logic        stall;
    logic [31:0] ALU_Res;
    logic [31:0] ST_val;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic [4:0]  Dest;

    exe_stage_md #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .EXE_CMD     (EXE_CMD),
        .val1        (val1),
        .val2        (val2),
        .ST_val_in   (ST_val_in),
        .MEM_R_EN_in (MEM_R_EN_in),
        .MEM_W_EN_in (MEM_W_EN_in),
        .WB_EN_in    (WB_EN_in),
        .Dest_in     (Dest_in),
        .freeze      (freeze),
        .stall       (stall),
        .ALU_Res     (ALU_Res),
        .ST_val      (ST_val),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .WB_EN       (WB_EN),
        .Dest        (Dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic [2:0]  ctl;
        logic [4:0]  dest;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_md(input logic [3:0] cmd);
`ifdef EXE_DIV_EN
        return (cmd == 4'd9) || (cmd == 4'd10);
`else
        return (cmd == 4'd9);
`endif
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh  = b[4:0];
        ext = {{32{a[31]}}, a} >> sh;
        case (cmd)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ~(a | b);
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return ext[31:0];
            4'd8:    return a >> sh;
            4'd11:   return m_hi;
            4'd12:   return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic pop_compare(input string tag);
        exp_t e;
        check_value({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_value({tag, "_alu"}, ALU_Res, e.alu);
            check_value({tag, "_st"}, ST_val, e.st);
            check_value({tag, "_ctl"}, 32'({MEM_R_EN, MEM_W_EN, WB_EN}), 32'(e.ctl));
            check_value({tag, "_dest"}, 32'(Dest), 32'(e.dest));
        end
        exp_q.delete();
    endtask

    task automatic issue(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] st, input logic [2:0] ctl,
                         input logic [4:0] d, input logic v);
        exp_t        e;
        int          n;
        logic [63:0] p;
        n = 0;
        while (stall && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check_value({tag, "_issue_wait"}, 32'(stall), 32'd0);
        valid_in = v;
        EXE_CMD  = cmd;
        val1     = a;
        val2     = b;
        ST_val_in = st;
        {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in} = ctl;
        Dest_in  = d;
        if (!v || is_md(cmd)) begin
            e.alu = 32'd0; e.st = 32'd0; e.ctl = 3'b000; e.dest = 5'd0;
        end else begin
            e.alu = ref_alu(cmd, a, b); e.st = st; e.ctl = ctl; e.dest = d;
        end
        if (v && cmd == 4'd9) begin
            p    = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
`ifdef EXE_DIV_EN
        if (v && cmd == 4'd10) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFFFFFF;
                m_hi = a;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end
`endif
        exp_q.push_back(e);
        step();
        valid_in = 1'b0;
        pop_compare(tag);
    endtask

    task automatic run_md(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input int fz_at, input int fz_len);
        int cycles;
        int exp_cycles;
        cycles = 0;
        issue(tag, cmd, a, b, 32'h1234_0000, 3'b111, 5'd9, 1'b1);
        exp_cycles = is_md(cmd) ? (32 + fz_len) : 0;
        while (stall && cycles < 200) begin
            check_value({tag, "_busy_ctl"}, 32'({MEM_R_EN, MEM_W_EN, WB_EN}), 32'd0);
            freeze = (cycles >= fz_at) && (cycles < fz_at + fz_len);
            step();
            cycles++;
        end
        freeze = 1'b0;
        check_value({tag, "_stall_cycles"}, 32'(cycles), 32'(exp_cycles));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; EXE_CMD = 4'd0; val1 = 32'd0; val2 = 32'd0;
        ST_val_in = 32'd0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;
        Dest_in = 5'd0; freeze = 1'b0;
        step();
        step();
        check_value("rst_alu", ALU_Res, 32'd0);
        check_value("rst_st", ST_val, 32'd0);
        check_value("rst_ctl", 32'({MEM_R_EN, MEM_W_EN, WB_EN}), 32'd0);
        check_value("rst_dest", 32'(Dest), 32'd0);
        check_value("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        issue("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1, 32'h0000A5A5, 3'b001, 5'd3, 1'b1);
        check_value("add_ovf_const", ALU_Res, 32'h80000000);
        check_value("add_stall", 32'(stall), 32'd0);
        issue("sub", 4'd1, 32'd5, 32'd7, 32'd0, 3'b001, 5'd4, 1'b1);
        issue("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd1, 3'b001, 5'd5, 1'b1);
        issue("or",  4'd3, 32'hF000_0001, 32'h0000_0F00, 32'd2, 3'b001, 5'd6, 1'b1);
        issue("nor", 4'd4, 32'hF000_0001, 32'h0000_0F00, 32'd3, 3'b001, 5'd7, 1'b1);
        issue("xor", 4'd5, 32'hAAAA_5555, 32'hFFFF_0000, 32'd4, 3'b001, 5'd8, 1'b1);
        issue("sll", 4'd6, 32'h0000_0001, 32'h0000_003F, 32'd5, 3'b001, 5'd9, 1'b1);
        issue("sra", 4'd7, 32'h8000_0000, 32'h0000_0024, 32'd6, 3'b001, 5'd10, 1'b1);
        check_value("sra_const", ALU_Res, 32'hF8000000);
        issue("srl", 4'd8, 32'h8000_0000, 32'd4, 32'd7, 3'b001, 5'd11, 1'b1);
        check_value("srl_const", ALU_Res, 32'h08000000);
        issue("store", 4'd0, 32'h0000_1000, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 5'd0, 1'b1);
        issue("cmd14", 4'd14, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b110, 5'd12, 1'b1);
        issue("bubble", 4'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b111, 5'd13, 1'b0);

        run_md("multu", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        issue("mfhi_mul", 4'd11, 32'd0, 32'd0, 32'd0, 3'b001, 5'd2, 1'b1);
        check_value("mfhi_mul_const", ALU_Res, 32'hFFFFFFFE);
        issue("mflo_mul", 4'd12, 32'd0, 32'd0, 32'd0, 3'b001, 5'd3, 1'b1);
        check_value("mflo_mul_const", ALU_Res, 32'h00000001);

        run_md("divu", 4'd10, 32'd100, 32'd7, 0, 0);
        issue("mflo_div", 4'd12, 32'd0, 32'd0, 32'd0, 3'b001, 5'd2, 1'b1);
`ifdef EXE_DIV_EN
        check_value("mflo_div_const", ALU_Res, 32'd14);
`endif
        issue("mfhi_div", 4'd11, 32'd0, 32'd0, 32'd0, 3'b001, 5'd3, 1'b1);
`ifdef EXE_DIV_EN
        check_value("mfhi_div_const", ALU_Res, 32'd2);
`endif
        run_md("divu0", 4'd10, 32'd5, 32'd0, 0, 0);
        issue("mflo_div0", 4'd12, 32'd0, 32'd0, 32'd0, 3'b001, 5'd2, 1'b1);
        issue("mfhi_div0", 4'd11, 32'd0, 32'd0, 32'd0, 3'b001, 5'd3, 1'b1);

        run_md("multu_fz", 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 10, 3);
        issue("mfhi_fz", 4'd11, 32'd0, 32'd0, 32'd0, 3'b001, 5'd2, 1'b1);
        issue("mflo_fz", 4'd12, 32'd0, 32'd0, 32'd0, 3'b001, 5'd3, 1'b1);

        issue("divu_rst", 4'd10, 32'd100, 32'd7, 32'd0, 3'b000, 5'd1, 1'b1);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_value("rst_mid_stall", 32'(stall), 32'd0);
        check_value("rst_mid_alu", ALU_Res, 32'd0);
        check_value("rst_mid_st", ST_val, 32'd0);
        check_value("rst_mid_ctl", 32'({MEM_R_EN, MEM_W_EN, WB_EN}), 32'd0);
        check_value("rst_mid_dest", 32'(Dest), 32'd0);
        issue("mfhi_rst", 4'd11, 32'd0, 32'd0, 32'd0, 3'b001, 5'd2, 1'b1);
        issue("mflo_rst", 4'd12, 32'd0, 32'd0, 32'd0, 3'b001, 5'd3, 1'b1);
        issue("add_after", 4'd0, 32'd2, 32'd3, 32'd0, 3'b001, 5'd4, 1'b1);
        check_value("add_after_const", ALU_Res, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
